// File: rtl/boa_div_seq.sv
// ============================================================================
//  boa_div_seq : iterative restoring divider sequencer with req/res handshake
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module boa_div_seq #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_u,
  input  logic [31:0] req_lhs,
  input  logic [31:0] req_rhs,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_quot,
  output logic [31:0] res_rem,
  output logic        busy,
  output logic        stall_req
);

  localparam int c_n     = 32 / BITS_PER_CYCLE;
  localparam int c_cnt_w = $clog2(c_n);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2, DONE = 2'd3} state_t;

  state_t               r_state, w_next;
  logic [31:0]          r_dvd, r_dvs, r_rem;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_q_neg, r_r_neg;

  logic                 w_accept, w_signed, w_div0, w_ovf;
  logic [31:0]          w_lhs_abs, w_rhs_abs, w_rem, w_dvd;
  logic [32:0]          w_trial;

  assign req_ready = (r_state == IDLE) && !clear;
  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign stall_req = (r_state == CALC) || (r_state == FIXUP) ||
                     ((r_state == IDLE) && req_valid && !clear);

  assign w_accept  = req_valid && req_ready;
  assign w_signed  = !req_u;
  assign w_lhs_abs = (w_signed && req_lhs[31]) ? (32'd0 - req_lhs) : req_lhs;
  assign w_rhs_abs = (w_signed && req_rhs[31]) ? (32'd0 - req_rhs) : req_rhs;
  assign w_div0    = (req_rhs == 32'd0);
  assign w_ovf     = w_signed && (req_lhs == 32'h8000_0000) && (req_rhs == 32'hFFFF_FFFF);

  // The dividend register doubles as the quotient: each step shifts a
  // dividend bit out of the top and a quotient bit in at the bottom.
  always_comb begin
    w_rem   = r_rem;
    w_dvd   = r_dvd;
    w_trial = 33'd0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_trial = {w_rem, w_dvd[31]} - {1'b0, r_dvs};
      if (!w_trial[32]) w_rem = w_trial[31:0];
      else              w_rem = {w_rem[30:0], w_dvd[31]};
      w_dvd = {w_dvd[30:0], ~w_trial[32]};
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = (w_div0 || w_ovf) ? DONE : CALC;
      CALC:    if (r_cnt == '0) w_next = FIXUP;
      FIXUP:   w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (clear) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      res_quot <= '0;
      res_rem  <= '0;
    end else if (!clear) begin
      if (w_accept) begin
        r_dvd   <= w_lhs_abs;
        r_dvs   <= w_rhs_abs;
        r_rem   <= '0;
        r_cnt   <= c_cnt_w'(c_n - 1);
        r_q_neg <= w_signed && (req_lhs[31] ^ req_rhs[31]);
        r_r_neg <= w_signed && req_lhs[31];
        if (w_div0) begin
          res_quot <= 32'hFFFF_FFFF;
          res_rem  <= req_lhs;
        end else if (w_ovf) begin
          res_quot <= 32'h8000_0000;
          res_rem  <= 32'd0;
        end
      end else if (r_state == CALC) begin
        r_rem <= w_rem;
        r_dvd <= w_dvd;
        r_cnt <= r_cnt - 1'b1;
      end else if (r_state == FIXUP) begin
        res_quot <= r_q_neg ? (32'd0 - r_dvd) : r_dvd;
        res_rem  <= r_r_neg ? (32'd0 - r_rem) : r_rem;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_boa_div_seq.sv
// ============================================================================
//  tb_boa_div_seq : directed checks of boa_div_seq at 1, 2 and 4 bits/cycle
//  Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_boa_div_seq;

  logic        clk, rst_n, clear, req_valid, req_u, res_ready;
  logic [31:0] req_lhs, req_rhs;
  logic        v[3], rdy[3], bsy[3], stl[3];
  logic [31:0] q[3], rm[3];

  int tests = 0;
  int fails = 0;
  int lat[3];
  int stall_cnt;
  logic [31:0] eq, er, ra, rb;
  logic        ru;

  boa_div_seq #(.BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_u(req_u), .req_lhs(req_lhs), .req_rhs(req_rhs), .res_valid(v[0]),
    .res_ready(res_ready), .res_quot(q[0]), .res_rem(rm[0]), .busy(bsy[0]), .stall_req(stl[0]));
  boa_div_seq #(.BITS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_u(req_u), .req_lhs(req_lhs), .req_rhs(req_rhs), .res_valid(v[1]),
    .res_ready(res_ready), .res_quot(q[1]), .res_rem(rm[1]), .busy(bsy[1]), .stall_req(stl[1]));
  boa_div_seq #(.BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid), .req_ready(rdy[2]),
    .req_u(req_u), .req_lhs(req_lhs), .req_rhs(req_rhs), .res_valid(v[2]),
    .res_ready(res_ready), .res_quot(q[2]), .res_rem(rm[2]), .busy(bsy[2]), .stall_req(stl[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic u, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] qo, output logic [31:0] ro);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 32'd0) begin
      qo = 32'hFFFF_FFFF; ro = a;
    end else if (!u && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      qo = 32'h8000_0000; ro = 32'd0;
    end else if (u) begin
      qo = a / b; ro = a % b;
    end else begin
      qo = sa / sb; ro = sa % sb;
    end
  endfunction

  // Issue one request with res_ready low; return once all three hold a result.
  task automatic run_op(input logic u, input logic [31:0] a, input logic [31:0] b);
    req_u = u; req_lhs = a; req_rhs = b; req_valid = 1'b1;
    #1;
    check("req_ready_idle", 32'(rdy[0]), 32'd1);
    check("stall_on_req", 32'(stl[0]), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = '{0, 0, 0};
    stall_cnt = 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      for (int k = 0; k < 3; k++)
        if (v[k] && lat[k] == 0) lat[k] = cyc;
      if (stl[0]) stall_cnt++;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] xq, input logic [31:0] xr);
    for (int k = 0; k < 3; k++) begin
      check({tag, "_quot"}, q[k], xq);
      check({tag, "_rem"}, rm[k], xr);
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) check("valid_after_ready", 32'(v[k]), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
    req_u = 1'b0; req_lhs = '0; req_rhs = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", 32'(v[0]), 32'd0);
    check("rst_quot", q[0], 32'd0);
    check("rst_rem", rm[0], 32'd0);
    check("rst_busy", 32'(bsy[0]), 32'd0);
    check("rst_ready", 32'(rdy[0]), 32'd1);

    // Unsigned 100/7 with latency and stall profile
    run_op(1'b1, 32'd100, 32'd7);
    check("lat_bpc1", 32'(lat[0]), 32'd34);
    check("lat_bpc2", 32'(lat[1]), 32'd18);
    check("lat_bpc4", 32'(lat[2]), 32'd10);
    check("stall_cycles", 32'(stall_cnt), 32'd33);
    check("stall_in_done", 32'(stl[0]), 32'd0);
    check_res("u100_7", 32'd14, 32'd2);

    // Back-pressure: result held for 20 cycles
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(v[0]), 32'd1);
      check("bp_quot", q[0], 32'd14);
      check("bp_rem", rm[0], 32'd2);
      check("bp_ready", 32'(rdy[0]), 32'd0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check("bp_release_valid", 32'(v[0]), 32'd0);
    check("bp_release_busy", 32'(bsy[0]), 32'd0);
    run_op(1'b1, 32'd1000, 32'd10);
    check("bp_next_lat", 32'(lat[0]), 32'd34);
    check_res("u1000_10", 32'd100, 32'd0);
    release_res();

    run_op(1'b0, 32'hFFFF_FFF9, 32'd2);
    check_res("sm7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    release_res();
    run_op(1'b0, 32'd7, 32'hFFFF_FFFE);
    check_res("s7_m2", 32'hFFFF_FFFD, 32'd1);
    release_res();

    // Fast paths
    run_op(1'b0, 32'd5, 32'd0);
    check("div0s_lat", 32'(lat[0]), 32'd1);
    check("div0s_stall", 32'(stall_cnt), 32'd0);
    check_res("div0s", 32'hFFFF_FFFF, 32'd5);
    release_res();
    run_op(1'b1, 32'd5, 32'd0);
    check("div0u_lat", 32'(lat[0]), 32'd1);
    check_res("div0u", 32'hFFFF_FFFF, 32'd5);
    release_res();
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    check("ovf_lat", 32'(lat[0]), 32'd1);
    check_res("ovf", 32'h8000_0000, 32'd0);
    release_res();

    // clear on the 10th CALC cycle
    req_u = 1'b1; req_lhs = 32'd12345; req_rhs = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
      check("clr_no_valid", 32'(v[0]), 32'd0);
    end
    clear = 1'b1;
    @(posedge clk); #1;
    check("clr_busy", 32'(bsy[0]), 32'd0);
    check("clr_valid", 32'(v[0]), 32'd0);
    check("clr_stall", 32'(stl[0]), 32'd0);
    req_valid = 1'b1;
    #1;
    check("clr_req_ready", 32'(rdy[0]), 32'd0);
    check("clr_req_stall", 32'(stl[0]), 32'd0);
    @(posedge clk); #1;
    check("clr_not_accepted", 32'(bsy[0]), 32'd0);
    clear = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-CALC
    req_u = 1'b1; req_lhs = 32'd999; req_rhs = 32'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(v[0]), 32'd0);
    check("arst_busy", 32'(bsy[0]), 32'd0);
    check("arst_stall", 32'(stl[0]), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 32'hFFFF_FFFF, 32'd16);
    check("post_rst_lat", 32'(lat[0]), 32'd34);
    check_res("post_rst", 32'h0FFF_FFFF, 32'd15);
    release_res();

    // Sweep against the reference model
    for (int i = 0; i < 16; i++) begin
      ru = 1'($urandom_range(0, 1));
      ra = $urandom;
      if (i % 4 == 0) rb = 32'($urandom_range(0, 15));
      else            rb = $urandom >> $urandom_range(0, 31);
      if (i == 1) begin ru = 1'b0; ra = 32'h8000_0000; rb = 32'd3; end
      if (i == 2) begin ru = 1'b1; ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      ref_div(ru, ra, rb, eq, er);
      run_op(ru, ra, rb);
      check_res("sweep", eq, er);
      release_res();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/boa_div_seq.md
Name: boa_div_seq

Overview:
- Iterative 32-bit divider sequencer for the EX stage. It owns a shift-subtract divide datapath and its control FSM.
- Accepts one DIV/DIVU/REM/REMU operand pair per request and produces quotient and remainder together.
- Drives the EX stall request while a divide is pending.
- Replaces fixed-latency trigger/delay divide timing with a proper request/response handshake and abort.

Parameters:
- bits_per_cycle, 1, quotient bits resolved per CALC cycle. Legal values are 1, 2 and 4. N = 32/bits_per_cycle.

Ports:
- clk  in  1  CPU clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort: discard any operation in flight.
- req_valid  in  1  operands valid.
- req_ready  out  1  sequencer can accept a request.
- req_u  in  1  1 = unsigned (DIVU/REMU), 0 = signed.
- req_lhs  in  32  dividend.
- req_rhs  in  32  divisor.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer takes the result.
- res_quot  out  32  quotient.
- res_rem  out  32  remainder.
- busy  out  1  state is not IDLE.
- stall_req  out  1  EX stall request.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; res_valid = 0; res_quot = 0; res_rem = 0; busy = 0.
  - All internal registers are cleared.
  - Applies at any point, including mid-CALC.
- States: IDLE, CALC, FIXUP, DONE.
- req_ready = (state == IDLE) && !clear. A request is accepted on a clock edge with req_valid && req_ready.
- Acceptance:
  - Latch req_u.
  - Store |lhs| and |rhs|: magnitudes when signed, raw values when unsigned.
  - Store q_neg = signed && (lhs[31] ^ rhs[31]) and r_neg = signed && lhs[31].
  - Load the remainder accumulator with 0 and the step counter with N-1.
- Fast paths (IDLE -> DONE on the acceptance edge, no CALC):
  - rhs == 0: quot = 32'hFFFF_FFFF, rem = lhs. Applies to signed and unsigned.
  - Signed, lhs == 32'h8000_0000, rhs == 32'hFFFF_FFFF: quot = 32'h8000_0000, rem = 0.
- Normal path: IDLE -> CALC.
- CALC:
  - Each edge performs bits_per_cycle restoring steps: shift the remainder left by one and bring in the dividend MSB, trial-subtract the divisor, keep the result if non-negative, and shift the quotient bit in.
  - Use 33-bit subtraction so the unsigned borrow is exact.
  - Counter decrements; at counter == 0 the next state is FIXUP.
- FIXUP (one edge):
  - quot = q_neg ? -q : q.
  - rem = r_neg ? -r : r. Remainder sign follows the dividend.
  - Next state is DONE.
- DONE:
  - res_valid = 1; res_quot and res_rem are registered and stable.
  - On res_ready the next state is IDLE and res_valid drops.
  - Without res_ready the result is held indefinitely.
- Latency, counted in edges from the acceptance edge to the first cycle with res_valid high:
  - Normal path: N + 2 (34 for bits_per_cycle = 1, 18 for 2, 10 for 4).
  - Fast path: 1.
- Throughput: a new request is accepted no earlier than the cycle after the DONE->IDLE edge, so no back-to-back overlap.
- stall_req = (state == CALC) || (state == FIXUP) || (state == IDLE && req_valid && !clear). It is combinational and excludes DONE, so EX completes in the cycle res_valid is high.
- clear:
  - On the next edge, any state goes to IDLE and res_valid = 0.
  - A request presented in the same cycle is not accepted (req_ready is low).
  - res_quot and res_rem keep their old values; consumers ignore them while res_valid is low.
- Simultaneous DONE && res_ready && clear: goes to IDLE; same outcome as either alone.
- res_quot and res_rem change only on the FIXUP edge or the fast-path edge.

Test Plan:
- Unsigned 100/7, bits_per_cycle = 1 -> res_valid 34 edges after acceptance; quot = 14, rem = 2; stall_req high for 33 cycles, low in DONE.
- Signed -7/2 (32'hFFFF_FFF9, 2) -> quot = 32'hFFFF_FFFD, rem = 32'hFFFF_FFFF. Signed 7/-2 -> quot = 32'hFFFF_FFFD, rem = 1.
- Divide by zero: 5/0, signed and unsigned -> res_valid 1 edge after acceptance; quot = 32'hFFFF_FFFF, rem = 5. Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF -> quot = 32'h8000_0000, rem = 0.
- Back-pressure: hold res_ready = 0 for 20 cycles after DONE -> res_valid stays 1, outputs stable, req_ready = 0; res_ready = 1 -> IDLE next edge, and a new request is accepted one cycle later.
- clear asserted on the 10th CALC cycle -> IDLE next edge, res_valid never asserts, stall_req drops. A request with clear high is not accepted.
- rst_n pulsed low mid-CALC, asynchronously between edges -> res_valid, busy and stall_req go to 0 immediately; the operation after release (32'hFFFF_FFFF/16, unsigned) gives quot = 32'h0FFF_FFFF, rem = 15. Repeat the random signed/unsigned sweep for bits_per_cycle = 2 and 4 against a reference model.
